// File: rtl/csr_axil_write_responder_pkg.sv
// Shared types and constants for the CSR AXI-Lite write responder.
// Response codes, FSM states and CSR address field positions.
package csr_axil_pkg;

    localparam logic [2:0] BRESP_OKAY   = 3'd0;
    localparam logic [2:0] BRESP_SLVERR = 3'd2;

    // CSR address fields: 11:10 == 2'b11 marks read-only,
    // 9:8 is the lowest privilege allowed to access it.
    localparam int CSR_RO_HI   = 11;
    localparam int CSR_RO_LO   = 10;
    localparam int CSR_PRIV_HI = 9;
    localparam int CSR_PRIV_LO = 8;

    typedef enum logic [2:0] {
        IDLE,
        HAVE_ADDR,
        HAVE_DATA,
        CHECK,
        WRITE,
        RESP
    } state_e;

endpackage

// File: rtl/csr_axil_write_responder_if.sv
// AXI-Lite write channel bundle (AW, W, B) between commit and the CSR file.
// master drives requests, slave answers with ready and the B response.
interface csr_axil_write_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [RESP_WIDTH-1:0] bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/csr_axil_write_responder_access_check.sv
// Combinational CSR access check: read-only, privilege and implemented.
// Takes only the address field bits that matter; shared with the read side.
module csr_access_check (
    input  logic [3:0] addr_hi,
    input  logic [1:0] priv_level,
    input  logic       hit,
    output logic       err
);
    logic ro;
    logic priv_low;

    // Reject on RO region, insufficient privilege, or unimplemented address
    always_comb begin
        ro       = (addr_hi[3:2] == 2'b11);
        priv_low = (addr_hi[1:0] > priv_level);
        err      = ro | priv_low | ~hit;
    end
endmodule

// File: rtl/csr_axil_write_responder.sv
// AXI-Lite write responder in front of the CSR file write port.
// Collects AW and W in any order, checks access, writes, and returns B.
module csr_axil_write_responder
    import csr_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    csr_axil_write_responder_if.slave axil_csr,
    input  logic [1:0]            priv_level,
    output logic [ADDR_WIDTH-1:0] csr_lookup_addr,
    input  logic                  csr_lookup_hit,
    output logic [ADDR_WIDTH-1:0] csr_wr_addr,
    output logic [DATA_WIDTH-1:0] csr_wr_data,
    output logic                  csr_wr_en,
    input  logic                  csr_wr_ready
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [RESP_WIDTH-1:0] resp_q, resp_d;
    logic                  wr_en_q, wr_en_d;
    logic                  bvalid_q, bvalid_d;
    logic                  aw_hs, w_hs;
    logic                  access_err;

    csr_access_check u_check (
        .addr_hi    (addr_q[CSR_RO_HI:CSR_PRIV_LO]),
        .priv_level (priv_level),
        .hit        (csr_lookup_hit),
        .err        (access_err)
    );

    // Ready decode; forced low while reset is held
    always_comb begin
        axil_csr.awready = ~reset &
            ((state_q == IDLE) | (state_q == HAVE_DATA));
        axil_csr.wready  = ~reset &
            ((state_q == IDLE) | (state_q == HAVE_ADDR));
    end

    // Next-state, buffer capture and registered output flags
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        resp_d  = resp_q;
        aw_hs   = axil_csr.awvalid & axil_csr.awready;
        w_hs    = axil_csr.wvalid & axil_csr.wready;
        if (aw_hs) addr_d = axil_csr.awaddr;
        if (w_hs)  data_d = axil_csr.wdata;
        unique case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) state_d = CHECK;
                else if (aw_hs)    state_d = HAVE_ADDR;
                else if (w_hs)     state_d = HAVE_DATA;
            end
            HAVE_ADDR: if (w_hs)  state_d = CHECK;
            HAVE_DATA: if (aw_hs) state_d = CHECK;
            CHECK: begin
                if (access_err) begin
                    resp_d  = RESP_WIDTH'(BRESP_SLVERR);
                    state_d = RESP;
                end else begin
                    resp_d  = RESP_WIDTH'(BRESP_OKAY);
                    state_d = WRITE;
                end
            end
            WRITE: if (csr_wr_ready) state_d = RESP;
            RESP:  if (axil_csr.bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_en_d  = (state_d == WRITE);
        bvalid_d = (state_d == RESP);
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            resp_q   <= '0;
            wr_en_q  <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            resp_q   <= resp_d;
            wr_en_q  <= wr_en_d;
            bvalid_q <= bvalid_d;
        end
    end

    // Output drive from registered state
    always_comb begin
        csr_lookup_addr = addr_q;
        csr_wr_addr     = addr_q;
        csr_wr_data     = data_q;
        csr_wr_en       = wr_en_q;
        axil_csr.bvalid = bvalid_q;
        axil_csr.bresp  = resp_q;
    end
endmodule
